// File: rtl/tb_run_ctrl.sv
// Bench run controller: sequences DUT reset, counts run cycles and ends the run
// on halt, cycle timeout or stall, reporting a sticky status and an end pulse.
module tb_run_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MAX_CYCLES  = 100,
  parameter int RST_HOLD    = 2,
  parameter int STALL_LIMIT = 0,
  parameter int CODE_W      = 8,
  parameter int FINISH_EN   = 1
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              halt_valid,
  input  logic [CODE_W-1:0] halt_code,
  input  logic              progress,
  output logic              dut_aresetn,
  output logic              running,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              end_pulse,
  output logic [1:0]        status,
  output logic [CODE_W-1:0] end_code
);

  typedef enum logic [2:0] {S_HOLD, S_RUN, S_PASS, S_FAIL, S_STALL} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] MAX_C      = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   hold_cnt, hold_nxt, stall_cnt, stall_nxt, cnt_nxt;
  logic               dut_rst_nxt, pulse_nxt;
  logic [1:0]         status_nxt;
  logic [CODE_W-1:0]  code_nxt;

  assign running = (state == S_RUN);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= S_HOLD;
      hold_cnt    <= '0;
      stall_cnt   <= '0;
      cycle_count <= '0;
      dut_aresetn <= 1'b0;
      end_pulse   <= 1'b0;
      status      <= 2'd0;
      end_code    <= '0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      stall_cnt   <= stall_nxt;
      cycle_count <= cnt_nxt;
      dut_aresetn <= dut_rst_nxt;
      end_pulse   <= pulse_nxt;
      status      <= status_nxt;
      end_code    <= code_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    stall_nxt   = stall_cnt;
    cnt_nxt     = cycle_count;
    dut_rst_nxt = dut_aresetn;
    pulse_nxt   = 1'b0;
    status_nxt  = status;
    code_nxt    = end_code;
    case (state)
      S_HOLD: begin
        hold_nxt = hold_cnt + 1'b1;
        if (hold_cnt == HOLD_LAST) begin
          state_nxt   = S_RUN;
          dut_rst_nxt = 1'b1;
        end
      end
      S_RUN: begin
        // the ending edge still counts, so a halt seen at count N freezes at N+1
        cnt_nxt   = (cycle_count == CNT_SAT) ? cycle_count : cycle_count + 1'b1;
        stall_nxt = progress ? '0 : stall_cnt + 1'b1;
        if (halt_valid) begin
          pulse_nxt = 1'b1;
          code_nxt  = halt_code;
          if (halt_code == '0) begin
            state_nxt  = S_PASS;
            status_nxt = 2'd1;
          end else begin
            state_nxt  = S_FAIL;
            status_nxt = 2'd2;
          end
        end else if (STALL_LIMIT != 0 && !progress && stall_cnt == STALL_LAST) begin
          pulse_nxt  = 1'b1;
          state_nxt  = S_STALL;
          status_nxt = 2'd3;
          code_nxt   = '1;
        end else if (cycle_count == MAX_C) begin
          pulse_nxt  = 1'b1;
          state_nxt  = S_FAIL;
          status_nxt = 2'd2;
          code_nxt   = '1;
        end
      end
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  if (FINISH_EN != 0) begin : g_finish
    always @(posedge clk) begin
      if (end_pulse) begin
        $display("run_ctrl: status=%0d code=%0h cycles=%0d", status, end_code, cycle_count);
        $finish;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tb_run_ctrl.sv
// Bench for tb_run_ctrl: scenario table, hand-written reset sequences and
// randomized runs against an outcome model.
module tb_tb_run_ctrl;
  localparam int MAXC = 100;
  localparam int STL  = 5;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        halt_valid = 1'b0;
  logic [7:0]  halt_code = 8'h0;
  logic        progress = 1'b0;
  logic        dut_aresetn, running, end_pulse;
  logic [31:0] cycle_count;
  logic [1:0]  status;
  logic [7:0]  end_code;

  int checks = 0;
  int errors = 0;

  logic       hv [0:255];
  logic [7:0] hc [0:255];
  logic       pv [0:255];

  tb_run_ctrl #(.CNT_W(32), .MAX_CYCLES(MAXC), .RST_HOLD(2), .STALL_LIMIT(STL),
                .CODE_W(8), .FINISH_EN(0)) dut (
    .clk(clk), .aresetn(aresetn), .halt_valid(halt_valid), .halt_code(halt_code),
    .progress(progress), .dut_aresetn(dut_aresetn), .running(running),
    .cycle_count(cycle_count), .end_pulse(end_pulse), .status(status),
    .end_code(end_code));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string name;
    int    halt_at;   // -1: never halts
    int    code;
    int    prog_per;  // 0 never, 1 always, N: pulse every N cycles
    int    exp_status;
    int    exp_code;
    int    exp_count;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int halt_at, input int code, input int prog_per);
    for (int k = 0; k < 256; k++) begin
      hv[k] = (k == halt_at);
      hc[k] = hv[k] ? code[7:0] : 8'($urandom);
      pv[k] = (prog_per == 1) ? 1'b1 :
              (prog_per == 0) ? 1'b0 : ((k % prog_per) == prog_per - 1);
    end
  endtask

  // Outcome from the rules: first RUN edge with halt, a 5-long run of
  // no-progress edges, or the edge where MAXC edges have already elapsed.
  task automatic model(output int st, output int code, output int cnt);
    int z = 0;
    st = 0; code = 0; cnt = 0;
    for (int k = 0; k < 256; k++) begin
      if (hv[k]) begin
        st = (hc[k] == 0) ? 1 : 2; code = hc[k]; cnt = k + 1; return;
      end
      z = pv[k] ? 0 : z + 1;
      if (z == STL) begin st = 3; code = 255; cnt = k + 1; return; end
      if (k == MAXC) begin st = 2; code = 255; cnt = k + 1; return; end
    end
  endtask

  // Reset, then release; halt is driven during HOLD to show it is ignored.
  task automatic reset_release(input string tag);
    @(negedge clk);
    aresetn = 1'b0; halt_valid = 1'b1; halt_code = 8'h0; progress = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, " rst dut_aresetn"}, dut_aresetn, 0);
    chk({tag, " rst status"}, status, 0);
    chk({tag, " rst end_code"}, end_code, 0);
    chk({tag, " rst count"}, cycle_count, 0);
    chk({tag, " rst running"}, running, 0);
    chk({tag, " rst end_pulse"}, end_pulse, 0);
    aresetn = 1'b1;
    @(posedge clk); @(negedge clk);
    chk({tag, " hold1 dut_aresetn"}, dut_aresetn, 0);
    chk({tag, " hold1 running"}, running, 0);
    @(posedge clk); @(negedge clk);
    chk({tag, " hold2 dut_aresetn"}, dut_aresetn, 1);
    chk({tag, " hold2 running"}, running, 1);
    chk({tag, " hold2 count"}, cycle_count, 0);
  endtask

  task automatic run_check(input string tag, input int est, input int ecode, input int ecnt);
    int pulses = 0;
    bit ended = 0;
    for (int k = 0; k < 200; k++) begin
      halt_valid = hv[k]; halt_code = hc[k]; progress = pv[k];
      @(posedge clk); @(negedge clk);
      if (end_pulse) pulses++;
      if (!running) begin ended = 1; break; end
      chk({tag, " count"}, cycle_count, k + 1);
    end
    chk({tag, " ended"}, ended, 1);
    for (int i = 0; i < 4; i++) begin
      halt_valid = 1'b1; halt_code = 8'($urandom); progress = 1'b0;
      @(posedge clk); @(negedge clk);
      if (end_pulse) pulses++;
    end
    chk({tag, " status"}, status, est);
    chk({tag, " end_code"}, end_code, ecode);
    chk({tag, " frozen count"}, cycle_count, ecnt);
    chk({tag, " pulses"}, pulses, 1);
    chk({tag, " dut_aresetn held"}, dut_aresetn, 1);
    chk({tag, " running low"}, running, 0);
  endtask

  initial begin
    vec_t vecs[9];
    int st, cd, cn;
    vecs[0] = '{"pass@10",       10, 0,    1, 1, 0,   11};
    vecs[1] = '{"failcode@10",   10, 8'h3C, 1, 2, 8'h3C, 11};
    vecs[2] = '{"timeout",       -1, 0,    1, 2, 255, 101};
    vecs[3] = '{"stall",         -1, 0,    0, 3, 255, 5};
    vecs[4] = '{"prog_every4",   -1, 0,    4, 2, 255, 101};
    vecs[5] = '{"pass_on_tmo",  100, 0,    1, 1, 0,   101};
    vecs[6] = '{"fail_on_tmo",  100, 7,    1, 2, 7,   101};
    vecs[7] = '{"halt_vs_stall", 4,  0,    0, 1, 0,   5};
    vecs[8] = '{"halt_first",    0, 8'h80, 0, 2, 8'h80, 1};

    for (int i = 0; i < 9; i++) begin
      fill(vecs[i].halt_at, vecs[i].code, vecs[i].prog_per);
      reset_release(vecs[i].name);
      run_check(vecs[i].name, vecs[i].exp_status, vecs[i].exp_code, vecs[i].exp_count);
    end

    // mid-run reset: DUT reset must drop without waiting for a clock edge
    fill(-1, 0, 1);
    reset_release("midrun");
    for (int k = 0; k < 50; k++) begin
      halt_valid = 1'b0; progress = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    chk("midrun count50", cycle_count, 50);
    #1 aresetn = 1'b0;
    #1;
    chk("midrun async dut_aresetn", dut_aresetn, 0);
    chk("midrun async count", cycle_count, 0);
    chk("midrun async running", running, 0);
    fill(20, 0, 1);
    reset_release("rerun");
    run_check("rerun", 1, 0, 21);

    for (int r = 0; r < 20; r++) begin
      int d = $urandom_range(0, 4);
      int ha = $urandom_range(0, 140);
      int co = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 255);
      fill(ha, co, 1);
      for (int k = 0; k < 256; k++) pv[k] = ($urandom_range(0, 3) < d);
      model(st, cd, cn);
      reset_release($sformatf("rnd%0d", r));
      run_check($sformatf("rnd%0d", r), st, cd, cn);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
